// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller for the fetch stage.
// Runs a one-cycle boot load of the initial address, then sequential fetch.
// Stalls on hazard or instruction-memory wait, redirects on taken branches
// with a one-cycle squash bubble, and parks in HALT until reset.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   stall                 hazard stall from decode (PC holds)
//   imem_ready            instruction memory data valid this cycle
//   branch_taken          resolved taken branch (one-cycle pulse)
//   branch_target         branch target, sampled with branch_taken
//   halt                  stop fetching, sticky until reset
//   sel_pc                PC select: 00 initial, 01 sequential, 10 branch_pc
//   enable_pc             PC register loads at the next edge
//   branch_pc             registered latched branch target
//   inst_valid            fetched instruction is valid for decode
//   squash                fetched instruction must be discarded
//   fetch_cnt             instructions accepted by decode (wrapping)
//   stall_cnt             RUN cycles with PC held (wrapping)
module fetch_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic [1:0]        sel_pc,
  output logic              enable_pc,
  output logic [ADDR_W-1:0] branch_pc,
  output logic              inst_valid,
  output logic              squash,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] SEL_INIT   = 2'b00;
  localparam logic [1:0] SEL_SEQ    = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   branch_pc_q, branch_pc_d;
  logic [CNT_W-1:0]    fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      branch_pc_q <= '0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      branch_pc_q <= branch_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state, combinational fetch controls and counter updates.
  always_comb begin
    state_d     = state_q;
    branch_pc_d = branch_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    sel_pc      = SEL_SEQ;
    enable_pc   = 1'b0;
    inst_valid  = 1'b0;
    squash      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        sel_pc    = SEL_INIT;
        enable_pc = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          // Halt outranks a same-cycle branch; branch_pc keeps its value.
          squash  = 1'b1;
          state_d = ST_HALT;
        end else if (branch_taken) begin
          squash      = 1'b1;
          branch_pc_d = branch_target;
          state_d     = ST_REDIRECT;
        end else begin
          enable_pc  = ~stall & imem_ready;
          inst_valid = imem_ready;
          if (!enable_pc) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_REDIRECT: begin
        // The PC must take the target no matter what stall/imem_ready say.
        sel_pc    = SEL_BRANCH;
        enable_pc = 1'b1;
        squash    = 1'b1;
        state_d   = halt ? ST_HALT : ST_RUN;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // inst_valid is only ever high in RUN, so this freezes in HALT too.
    if (inst_valid && !stall) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end
  end

  assign branch_pc = branch_pc_q;
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, table-driven checks of fetch_ctrl, plus
// hand-written sequences for halt freeze, counter wrap and async reset.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        imem_ready;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt;

  logic [1:0]  sel_pc;
  logic        enable_pc;
  logic [15:0] branch_pc;
  logic        inst_valid;
  logic        squash;
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;

  logic [1:0]  sel_pc4;
  logic        enable_pc4;
  logic [15:0] branch_pc4;
  logic        inst_valid4;
  logic        squash4;
  logic [3:0]  fetch_cnt4;
  logic [3:0]  stall_cnt4;

  int n_run;
  int n_fail;

  fetch_ctrl #(.ADDR_W(16), .CNT_W(16)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .sel_pc        (sel_pc),
    .enable_pc     (enable_pc),
    .branch_pc     (branch_pc),
    .inst_valid    (inst_valid),
    .squash        (squash),
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap check.
  fetch_ctrl #(.ADDR_W(16), .CNT_W(4)) u_dut4 (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .sel_pc        (sel_pc4),
    .enable_pc     (enable_pc4),
    .branch_pc     (branch_pc4),
    .inst_valid    (inst_valid4),
    .squash        (squash4),
    .fetch_cnt     (fetch_cnt4),
    .stall_cnt     (stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rdy;
    logic        br;
    logic        hlt;
    logic [15:0] tgt;
    logic [1:0]  sel;
    logic        en;
    logic        iv;
    logic        sq;
    logic [15:0] fc;
    logic [15:0] sc;
    logic [15:0] bpc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic r, logic b, logic h, logic [15:0] t,
                              logic [1:0] sel, logic en, logic iv, logic sq,
                              logic [15:0] fc, logic [15:0] sc, logic [15:0] bpc);
    vec_t v;
    v.stall = s; v.rdy = r; v.br = b; v.hlt = h; v.tgt = t;
    v.sel = sel; v.en = en; v.iv = iv; v.sq = sq;
    v.fc = fc; v.sc = sc; v.bpc = bpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic b, input logic h,
                       input logic [15:0] t);
    stall = s; imem_ready = r; branch_taken = b; halt = h; branch_target = t;
  endtask

  task automatic chk_comb(input string tag, input logic [1:0] sel, input logic en,
                          input logic iv, input logic sq);
    chk({tag, ".sel_pc"},     32'(sel_pc),     32'(sel));
    chk({tag, ".enable_pc"},  32'(enable_pc),  32'(en));
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(iv));
    chk({tag, ".squash"},     32'(squash),     32'(sq));
  endtask

  task automatic chk_regs(input string tag, input logic [15:0] fc, input logic [15:0] sc,
                          input logic [15:0] bpc);
    chk({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'(fc));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(sc));
    chk({tag, ".branch_pc"}, 32'(branch_pc), 32'(bpc));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);

    // Expectations per cycle: outputs in that cycle, registers before its edge.
    //            stl rdy br hlt tgt       sel   en iv sq  fc  sc  bpc
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b00, 1, 0, 0,  0,  0, 16'h0000)); // BOOT
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0,  0,  0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0,  1,  0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0,  2,  0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0,  3,  0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0,  4,  0, 16'h0000));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 2'b01, 0, 1, 0,  5,  0, 16'h0000)); // stall x3
    vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 2'b01, 0, 1, 0,  5,  1, 16'h0000));
    vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 2'b01, 0, 1, 0,  5,  2, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0,  5,  3, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0,  6,  3, 16'h0000));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 2'b01, 0, 0, 0,  7,  3, 16'h0000)); // imem wait
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0,  7,  4, 16'h0000));
    vecs.push_back(mk(0, 1, 1, 0, 16'h0040, 2'b01, 0, 0, 1,  8,  4, 16'h0000)); // branch
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b10, 1, 0, 1,  8,  4, 16'h0040)); // REDIRECT
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0,  8,  4, 16'h0040));
    vecs.push_back(mk(1, 1, 1, 0, 16'h0060, 2'b01, 0, 0, 1,  9,  4, 16'h0040)); // branch+stall
    vecs.push_back(mk(1, 0, 1, 0, 16'h0099, 2'b10, 1, 0, 1,  9,  4, 16'h0060)); // branch ignored
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b01, 1, 1, 0,  9,  4, 16'h0060));
    vecs.push_back(mk(1, 1, 1, 1, 16'h0080, 2'b01, 0, 0, 1, 10,  4, 16'h0060)); // halt wins
    vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 2'b01, 0, 0, 0, 10,  4, 16'h0060)); // HALT
    vecs.push_back(mk(0, 1, 1, 0, 16'h00aa, 2'b01, 0, 0, 0, 10,  4, 16'h0060));

    // Reset: outputs reflect BOOT while reset is held.
    repeat (2) begin
      @(negedge clk);
      chk_comb("reset", 2'b00, 1'b1, 1'b0, 1'b0);
      chk_regs("reset", 16'h0, 16'h0, 16'h0);
    end
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].stall, vecs[i].rdy, vecs[i].br, vecs[i].hlt, vecs[i].tgt);
      @(negedge clk);
      chk_comb(tag, vecs[i].sel, vecs[i].en, vecs[i].iv, vecs[i].sq);
      chk_regs(tag, vecs[i].fc, vecs[i].sc, vecs[i].bpc);
      @(posedge clk); #1;
    end

    // HALT is sticky and counters stay frozen under any input mix.
    for (int i = 0; i < 10; i++) begin
      drive(i[0], i[1], 1'b1, i[2], 16'h1111);
      @(negedge clk);
      chk("halt.enable_pc", 32'(enable_pc), 32'd0);
      chk("halt.inst_valid", 32'(inst_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk_regs("halt_end", 16'd10, 16'd4, 16'h0060);

    // Halt arriving during REDIRECT goes straight to HALT.
    do_reset();
    drive(0, 1, 0, 0, 16'h0);
    repeat (2) @(posedge clk);
    #1 drive(0, 1, 1, 0, 16'h0200);
    @(posedge clk); #1 drive(0, 1, 0, 1, 16'h0);
    @(negedge clk);
    chk_comb("redir_halt", 2'b10, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1 drive(0, 1, 0, 0, 16'h0);
    @(negedge clk);
    chk_comb("after_redir_halt", 2'b01, 1'b0, 1'b0, 1'b0);
    chk_regs("after_redir_halt", 16'd1, 16'd0, 16'h0200);

    // Wrap: 17 valid unstalled RUN cycles on a 4-bit counter leaves 1.
    do_reset();
    drive(0, 1, 0, 0, 16'h0);
    @(posedge clk);
    repeat (17) @(posedge clk);
    @(negedge clk);
    chk("wrap.fetch_cnt16", 32'(fetch_cnt), 32'd17);
    chk("wrap.fetch_cnt4", 32'(fetch_cnt4), 32'd1);

    // Asynchronous reset in the REDIRECT cycle.
    @(posedge clk); #1 drive(1, 0, 0, 0, 16'h0);
    @(posedge clk); #1 drive(0, 1, 1, 0, 16'h1234);
    @(posedge clk); #1 drive(0, 1, 0, 0, 16'h0);
    @(negedge clk);
    chk("pre_rst.sel_pc", 32'(sel_pc), 32'd2);
    chk("pre_rst.branch_pc", 32'(branch_pc), 32'h1234);
    #1 reset = 1'b1;
    #1;
    chk_comb("async_rst", 2'b00, 1'b1, 1'b0, 1'b0);
    chk_regs("async_rst", 16'h0, 16'h0, 16'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_comb("post_rst_boot", 2'b00, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
